// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: NOP encoding, instruction field positions and
// elastic-stage state encoding.
package cpu_pipe_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'hF000_0000;

  localparam int unsigned OPC_MSB   = 31;
  localparam int unsigned OPC_LSB   = 26;
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_MSB = 10;
  localparam int unsigned SHAMT_LSB = 6;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned IMM21_MSB = 20;
  localparam int unsigned IMM21_LSB = 0;
  localparam int unsigned IMM26_MSB = 25;
  localparam int unsigned IMM26_LSB = 0;

  // State is the pair {main valid, skid valid}.
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] HALF  = 2'b10;
  localparam logic [1:0] FULL  = 2'b11;

  typedef enum logic [1:0] {
    StEmpty = EMPTY,
    StHalf  = HALF,
    StFull  = FULL
  } pipe_state_e;

endpackage

// File: rtl/ifid_elastic_reg_if.sv
// Valid/ready instruction bus: master drives valid/instr/pc, slave drives ready.
interface ifid_elastic_reg_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_W    = 32
);
  logic               valid;
  logic               ready;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    pc;

  modport master (output valid, output instr, output pc, input ready);
  modport slave  (input valid, input instr, input pc, output ready);
endinterface

// File: rtl/instr_field_split.sv
// Purely combinational split of an instruction word into decode fields.
// Bits above 31 are carried elsewhere and not decoded here.
module instr_field_split
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] instr_i,
  output logic [5:0]         opcode_o,
  output logic [4:0]         rs_o,
  output logic [4:0]         rt_o,
  output logic [4:0]         rd_o,
  output logic [4:0]         shamt_o,
  output logic [5:0]         funct_o,
  output logic [20:0]        imm21_o,
  output logic [25:0]        imm26_o
);

  assign opcode_o = instr_i[OPC_MSB:OPC_LSB];
  assign rs_o     = instr_i[RS_MSB:RS_LSB];
  assign rt_o     = instr_i[RT_MSB:RT_LSB];
  assign rd_o     = instr_i[RD_MSB:RD_LSB];
  assign shamt_o  = instr_i[SHAMT_MSB:SHAMT_LSB];
  assign funct_o  = instr_i[FUNCT_MSB:FUNCT_LSB];
  assign imm21_o  = instr_i[IMM21_MSB:IMM21_LSB];
  assign imm26_o  = instr_i[IMM26_MSB:IMM26_LSB];

endmodule

// File: rtl/ifid_elastic_reg.sv
// IF/ID elastic pipeline register with optional one-entry skid buffer,
// synchronous flush to NOP and decoded field outputs.
module ifid_elastic_reg
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned        INSTR_W   = 32,
  parameter int unsigned        PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
  parameter bit                 SKID_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  ifid_elastic_reg_if.slave   in_if,
  ifid_elastic_reg_if.master  out_if,
  output logic [5:0]          out_opcode,
  output logic [4:0]          out_rs,
  output logic [4:0]          out_rt,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_shamt,
  output logic [5:0]          out_funct,
  output logic [20:0]         out_imm21,
  output logic [25:0]         out_imm26
);

  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [PC_W-1:0]    out_pc_q, out_pc_d;
  logic               skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;

  logic        in_ready;
  logic        in_hs;
  logic        out_hs;
  pipe_state_e state;

  // With the skid buffer, ready is a pure flop output so fetch never sees decode's stall.
  assign in_ready = SKID_EN ? !skid_valid_q : (!out_valid_q || out_if.ready);
  assign in_hs    = in_if.valid && in_ready;
  assign out_hs   = out_valid_q && out_if.ready;
  assign state    = pipe_state_e'({out_valid_q, skid_valid_q});

  // Next-state: flush wins, then the EMPTY/HALF/FULL handshake rules.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      out_instr_d  = NOP_INSTR;
      skid_valid_d = 1'b0;
    end else if (SKID_EN) begin
      unique case (state)
        StEmpty: begin
          if (in_hs) begin
            out_valid_d = 1'b1;
            out_instr_d = in_if.instr;
            out_pc_d    = in_if.pc;
          end
        end
        StHalf: begin
          if (in_hs && out_hs) begin
            out_instr_d = in_if.instr;
            out_pc_d    = in_if.pc;
          end else if (in_hs) begin
            skid_valid_d = 1'b1;
            skid_instr_d = in_if.instr;
            skid_pc_d    = in_if.pc;
          end else if (out_hs) begin
            out_valid_d = 1'b0;
          end
        end
        StFull: begin
          if (out_hs) begin
            out_instr_d  = skid_instr_q;
            out_pc_d     = skid_pc_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          // Skid-only occupancy cannot arise; drop it.
          skid_valid_d = 1'b0;
        end
      endcase
    end else begin
      if (in_hs) begin
        out_valid_d = 1'b1;
        out_instr_d = in_if.instr;
        out_pc_d    = in_if.pc;
      end else if (out_hs) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Stage registers with asynchronous reset to the NOP/empty state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= NOP_INSTR;
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid_q;
  assign out_if.instr = out_instr_q;
  assign out_if.pc    = out_pc_q;

  instr_field_split #(
    .INSTR_W (INSTR_W)
  ) u_split (
    .instr_i  (out_instr_q),
    .opcode_o (out_opcode),
    .rs_o     (out_rs),
    .rt_o     (out_rt),
    .rd_o     (out_rd),
    .shamt_o  (out_shamt),
    .funct_o  (out_funct),
    .imm21_o  (out_imm21),
    .imm26_o  (out_imm26)
  );

endmodule
